// File: rtl/mem_port_responder_if.sv
// Requester-side memory port: read-address, read-data return and write channels.
// Valid/ready: a transfer occurs on a cycle where valid & ready; r_dvalid has no backpressure.
interface mem_port_responder_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_avalid;
   logic                  r_aready;
   logic                  r_dvalid;
   logic [DATA_WIDTH-1:0] r_data;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_valid;
   logic                  w_ready;

   modport master (
      output r_addr, r_avalid, w_addr, w_data, w_valid,
      input  r_aready, r_dvalid, r_data, w_ready
   );

   modport slave (
      input  r_addr, r_avalid, w_addr, w_data, w_valid,
      output r_aready, r_dvalid, r_data, w_ready
   );
endinterface

// File: rtl/mem_port_responder.sv
// Responder for one requester port: issues single commands to the shared backend RAM port,
// alternates reads and writes under contention, and caps reads in flight so returns never stall.
module mem_port_responder #(
   parameter int DATA_WIDTH      = 16,
   parameter int ADDR_WIDTH      = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_port_responder_if.slave   req,
   input  logic                  mem_gnt,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [3:0]            outstanding,
   output logic                  err_unexp
);
   localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

   logic [3:0]            out_q, out_d;
   logic                  last_wr_q, last_wr_d;
   logic                  err_q, err_d;
   logic                  dvalid_q, dvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic not_full, rd_ok, pick_wr, rd_acc, wr_acc;

   assign not_full = (out_q < MAX_OUT);
   assign rd_ok    = req.r_avalid & not_full;
   // A pending write wins unless the last issued command was itself a write.
   assign pick_wr  = req.w_valid & (~rd_ok | ~last_wr_q);

   assign req.w_ready  = mem_gnt & pick_wr;
   assign req.r_aready = mem_gnt & not_full & ~(req.w_valid & ~last_wr_q);

   assign rd_acc = req.r_avalid & req.r_aready;
   assign wr_acc = req.w_valid & req.w_ready;

   always_comb begin
      mem_en    = rd_acc | wr_acc;
      mem_we    = wr_acc;
      mem_addr  = '0;
      mem_wdata = '0;
      if (wr_acc) begin
         mem_addr  = req.w_addr;
         mem_wdata = req.w_data;
      end else if (rd_acc) begin
         mem_addr  = req.r_addr;
      end
   end

   always_comb begin
      out_d     = out_q;
      last_wr_d = last_wr_q;
      if (wr_acc) begin
         last_wr_d = 1'b1;
      end else if (rd_acc) begin
         last_wr_d = 1'b0;
      end
      case ({rd_acc, mem_rvalid})
         2'b10:   out_d = out_q + 4'd1;
         2'b01:   if (out_q != 4'd0) out_d = out_q - 4'd1;
         default: out_d = out_q;
      endcase
      // A return with nothing in flight is flagged but still forwarded.
      err_d    = err_q | (mem_rvalid & (out_q == 4'd0));
      dvalid_d = mem_rvalid;
      rdata_d  = mem_rvalid ? mem_rdata : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q     <= 4'd0;
         last_wr_q <= 1'b0;
         err_q     <= 1'b0;
         dvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         out_q     <= out_d;
         last_wr_q <= last_wr_d;
         err_q     <= err_d;
         dvalid_q  <= dvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   assign req.r_dvalid = dvalid_q;
   assign req.r_data   = rdata_q;
   assign outstanding  = out_q;
   assign err_unexp    = err_q;
endmodule

// File: tb/tb_mem_port_responder.sv
// Bench for mem_port_responder: arbitration vector table plus hand sequences for the
// multi-cycle corners, with a backend RAM model and an in-order read-data scoreboard.
module tb_mem_port_responder;
   localparam int LAT = 2;

   logic        clk;
   logic        rst;
   logic        mem_gnt;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   logic [3:0]  outstanding;
   logic        err_unexp;

   mem_port_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

   mem_port_responder #(
      .DATA_WIDTH(16), .ADDR_WIDTH(16), .MAX_OUTSTANDING(4)
   ) dut (
      .clk(clk), .rst(rst), .req(bus),
      .mem_gnt(mem_gnt), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .outstanding(outstanding), .err_unexp(err_unexp)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // next-cycle requester/backend controls, applied at the falling edge
   logic        n_rst = 1'b1, n_gnt = 1'b0;
   logic        n_r_avalid = 1'b0, n_w_valid = 1'b0;
   logic [15:0] n_r_addr = '0, n_w_addr = '0, n_w_data = '0;
   bit          be_hold = 1'b1;
   bit          allow_unexp = 1'b0;
   int          n_dvalid = 0;

   logic [15:0] be_mem  [logic [15:0]];
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] be_q[$];
   int          be_t[$];
   logic [15:0] exp_q[$];

   logic        s_rr, s_wr, s_en, s_we, s_dvalid, s_err, s_rvalid, s_rd_acc, s_wr_acc;
   logic [15:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_out;

   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : a;
   endfunction

   function automatic logic [15:0] be_rd(input logic [15:0] a);
      return be_mem.exists(a) ? be_mem[a] : a;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // driver: one clock cycle; inputs change at negedge, outputs sampled 1ns later
   task automatic step();
      @(negedge clk);
      rst          = n_rst;
      mem_gnt      = n_gnt;
      bus.r_avalid = n_r_avalid;
      bus.r_addr   = n_r_addr;
      bus.w_valid  = n_w_valid;
      bus.w_addr   = n_w_addr;
      bus.w_data   = n_w_data;
      if (!be_hold && be_q.size() > 0 && be_t[0] <= cyc) begin
         mem_rvalid = 1'b1;
         mem_rdata  = be_q.pop_front();
         void'(be_t.pop_front());
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = '0;
      end
      #1;
      s_rr     = bus.r_aready;
      s_wr     = bus.w_ready;
      s_en     = mem_en;
      s_we     = mem_we;
      s_addr   = mem_addr;
      s_wdata  = mem_wdata;
      s_dvalid = bus.r_dvalid;
      s_rdata  = bus.r_data;
      s_out    = outstanding;
      s_err    = err_unexp;
      s_rvalid = mem_rvalid;
      s_rd_acc = bus.r_avalid & bus.r_aready;
      s_wr_acc = bus.w_valid & bus.w_ready;
      // scoreboard: in-order read data
      if (s_dvalid) begin
         n_dvalid++;
         if (exp_q.size() > 0) begin
            check("rdata", 32'(s_rdata), 32'(exp_q.pop_front()));
         end else if (!allow_unexp) begin
            total++;
            bad++;
            $display("FAIL unexpected_dvalid act=1 exp=0 (cycle %0d)", cyc);
         end
      end
      if (s_rd_acc | s_wr_acc) check("single_accept", 32'(s_rd_acc & s_wr_acc), 0);
      if (s_rd_acc) exp_q.push_back(ref_rd(bus.r_addr));
      if (s_wr_acc) ref_mem[bus.w_addr] = bus.w_data;
      // backend RAM model consumes whatever the DUT issued
      if (s_en && !rst) begin
         if (s_we) be_mem[s_addr] = s_wdata;
         else begin
            be_q.push_back(be_rd(s_addr));
            be_t.push_back(cyc + LAT);
         end
      end
      cyc++;
   endtask

   task automatic idle();
      n_r_avalid = 1'b0;
      n_w_valid  = 1'b0;
   endtask

   task automatic drain(input int n);
      idle();
      be_hold = 1'b0;
      repeat (n) step();
      check("drain_exp_empty", 32'(exp_q.size()), 0);
      check("drain_outstanding", 32'(s_out), 0);
   endtask

   typedef struct {
      logic       gnt, wv, rv;
      logic       e_wr, e_rr, e_en, e_we;
      logic [3:0] e_out;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int acc;
      int dv0;
      tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4};

      // reset
      n_rst = 1'b1;
      repeat (2) step();
      n_rst = 1'b0;
      n_gnt = 1'b1;
      step();
      check("rst_dvalid", 32'(s_dvalid), 0);
      check("rst_rdata", 32'(s_rdata), 0);
      check("rst_outstanding", 32'(s_out), 0);
      check("rst_err", 32'(s_err), 0);
      check("rst_mem_en", 32'(s_en), 0);
      check("rst_mem_addr", 32'(s_addr), 0);

      // arbitration table, backend held so outstanding only climbs
      be_hold = 1'b1;
      for (int i = 0; i < 13; i++) begin
         n_gnt      = tbl[i].gnt;
         n_w_valid  = tbl[i].wv;
         n_w_addr   = 16'h0380 + 16'(i);
         n_w_data   = 16'hB000 + 16'(i);
         n_r_avalid = tbl[i].rv;
         n_r_addr   = 16'h0300 + 16'(i);
         step();
         check($sformatf("vec%0d_w_ready", i), 32'(s_wr), 32'(tbl[i].e_wr));
         check($sformatf("vec%0d_r_aready", i), 32'(s_rr), 32'(tbl[i].e_rr));
         check($sformatf("vec%0d_mem_en", i), 32'(s_en), 32'(tbl[i].e_en));
         check($sformatf("vec%0d_mem_we", i), 32'(s_we), 32'(tbl[i].e_we));
         check($sformatf("vec%0d_outstanding", i), 32'(s_out), 32'(tbl[i].e_out));
      end
      n_gnt = 1'b1;
      drain(16);

      // single read with two-cycle backend latency
      n_r_avalid = 1'b1;
      n_r_addr   = 16'h0010;
      step();
      check("single_r_aready", 32'(s_rr), 1);
      check("single_mem_en", 32'(s_en), 1);
      check("single_mem_we", 32'(s_we), 0);
      check("single_mem_addr", 32'(s_addr), 32'h0010);
      check("single_out0", 32'(s_out), 0);
      idle();
      step();
      check("single_out1", 32'(s_out), 1);
      step();
      check("single_rvalid", 32'(s_rvalid), 1);
      step();
      check("single_dvalid", 32'(s_dvalid), 1);
      check("single_rdata", 32'(s_rdata), 32'h0010);
      check("single_out_back", 32'(s_out), 0);

      // back-pressure: 8 reads, returns withheld at first
      be_hold    = 1'b1;
      acc        = 0;
      dv0        = n_dvalid;
      n_r_avalid = 1'b1;
      n_r_addr   = 16'h0110;
      repeat (10) begin
         step();
         if (s_rd_acc) begin
            acc++;
            n_r_addr = n_r_addr + 16'd1;
         end
      end
      check("bp_accepts", 32'(acc), 4);
      check("bp_full_out", 32'(s_out), 4);
      check("bp_full_aready", 32'(s_rr), 0);
      be_hold = 1'b0;
      step();
      check("bp_ret_rvalid", 32'(s_rvalid), 1);
      check("bp_ret_same_cycle_aready", 32'(s_rr), 0);
      step();
      check("bp_reopen_aready", 32'(s_rr), 1);
      if (s_rd_acc) begin
         acc++;
         n_r_addr = n_r_addr + 16'd1;
      end
      for (int k = 0; k < 40 && acc < 8; k++) begin
         step();
         if (s_rd_acc) begin
            acc++;
            n_r_addr = n_r_addr + 16'd1;
            if (acc == 8) n_r_avalid = 1'b0;
         end
      end
      check("bp_total_accepts", 32'(acc), 8);
      drain(16);
      check("bp_returns", 32'(n_dvalid - dv0), 8);

      // contention: write and read held together
      n_w_valid  = 1'b1;
      n_w_addr   = 16'h0400;
      n_w_data   = 16'hC000;
      n_r_avalid = 1'b1;
      n_r_addr   = 16'h0500;
      for (int k = 0; k < 6; k++) begin
         step();
         check($sformatf("cont%0d_mem_en", k), 32'(s_en), 1);
         check($sformatf("cont%0d_mem_we", k), 32'(s_we), 32'((k % 2) == 0));
         check($sformatf("cont%0d_ready_pair", k), 32'(s_rr & s_wr), 0);
         if (s_wr_acc) begin
            n_w_addr = n_w_addr + 16'd1;
            n_w_data = n_w_data + 16'd1;
         end
         if (s_rd_acc) n_r_addr = n_r_addr + 16'd1;
      end
      drain(12);

      // read-after-write to the same address
      n_w_valid = 1'b1;
      n_w_addr  = 16'h0212;
      n_w_data  = 16'hA012;
      step();
      check("raw_w_accept", 32'(s_wr_acc), 1);
      check("raw_w_mem_we", 32'(s_we), 1);
      check("raw_w_mem_addr", 32'(s_addr), 32'h0212);
      check("raw_w_mem_wdata", 32'(s_wdata), 32'hA012);
      n_w_valid  = 1'b0;
      n_r_avalid = 1'b1;
      n_r_addr   = 16'h0212;
      step();
      check("raw_r_accept", 32'(s_rd_acc), 1);
      check("raw_r_mem_we", 32'(s_we), 0);
      check("raw_r_mem_addr", 32'(s_addr), 32'h0212);
      drain(8);
      check("raw_rdata", 32'(s_rdata), 32'hA012);

      // simultaneous accept and return at MAX_OUTSTANDING-1
      be_hold    = 1'b1;
      acc        = 0;
      n_r_avalid = 1'b1;
      n_r_addr   = 16'h0600;
      for (int k = 0; k < 10 && acc < 3; k++) begin
         step();
         if (s_rd_acc) begin
            acc++;
            n_r_addr = n_r_addr + 16'd1;
            if (acc == 3) n_r_avalid = 1'b0;
         end
      end
      step();
      step();
      check("sim_pre_out", 32'(s_out), 3);
      n_r_avalid = 1'b1;
      be_hold    = 1'b0;
      step();
      check("sim_rvalid", 32'(s_rvalid), 1);
      check("sim_accept", 32'(s_rd_acc), 1);
      n_r_avalid = 1'b0;
      be_hold    = 1'b1;
      step();
      check("sim_out_unchanged", 32'(s_out), 3);
      check("sim_aready_open", 32'(s_rr), 1);
      drain(12);

      // grant gating
      n_gnt      = 1'b0;
      n_w_valid  = 1'b1;
      n_w_addr   = 16'h0777;
      n_w_data   = 16'h5555;
      n_r_avalid = 1'b1;
      n_r_addr   = 16'h0700;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("gnt%0d_mem_en", k), 32'(s_en), 0);
         check($sformatf("gnt%0d_ready", k), 32'({s_rr, s_wr}), 0);
      end

      // reset with two reads in flight, then late returns
      n_gnt     = 1'b1;
      n_w_valid = 1'b0;
      be_hold   = 1'b1;
      acc       = 0;
      for (int k = 0; k < 10 && acc < 2; k++) begin
         step();
         if (s_rd_acc) begin
            acc++;
            n_r_addr = n_r_addr + 16'd1;
            if (acc == 2) n_r_avalid = 1'b0;
         end
      end
      step();
      check("rstmid_out2", 32'(s_out), 2);
      n_rst = 1'b1;
      step();
      n_rst = 1'b0;
      exp_q.delete();
      allow_unexp = 1'b1;
      step();
      check("rstmid_out0", 32'(s_out), 0);
      check("rstmid_err0", 32'(s_err), 0);
      check("rstmid_dvalid0", 32'(s_dvalid), 0);
      be_hold = 1'b0;
      step();
      check("late_rvalid", 32'(s_rvalid), 1);
      step();
      check("late_err", 32'(s_err), 1);
      check("late_dvalid", 32'(s_dvalid), 1);
      check("late_rdata", 32'(s_rdata), 32'h0700);
      check("late_out", 32'(s_out), 0);
      repeat (4) step();
      check("late_err_sticky", 32'(s_err), 1);
      check("late_out_final", 32'(s_out), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
